// File: rtl/sky130_sram_ctrl_pkg.sv
// Shared types and constants for the sky130 1rw1r port-0 controller.
// Contents:
//   req_t         request payload {write, addr, wdata} at the default macro geometry
//   READ_LATENCY  edges from issue to dout0 capture
//   INFLIGHT_W    width able to hold the number of reads in the issue pipeline
//   credit_width  width able to hold fifo_count + inflight for a given FIFO depth
package sky130_sram_ctrl_pkg;

    localparam int unsigned REQ_DATA_WIDTH = 8;
    localparam int unsigned REQ_ADDR_WIDTH = 4;
    localparam int unsigned READ_LATENCY   = 2;
    localparam int unsigned INFLIGHT_W     = $clog2(READ_LATENCY + 1);
    localparam int unsigned STAT_W         = 32;

    typedef struct packed {
        logic                      write;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } req_t;

    // Bits needed for fifo_count + inflight without overflow.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + READ_LATENCY + 1);
    endfunction

endpackage

// File: rtl/sky130_sram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears pointers and count)
//   push, push_data     write side; push at full is taken only together with a pop
//   pop                 read side; ignored when empty
//   pop_data            head entry, stable until popped
//   count, empty        occupancy
// DEPTH must be a power of two so pointers wrap naturally.
module sky130_sram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;
    logic                  full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

endmodule

// File: rtl/sky130_sram_rw_port_ctrl.sv
// Initiator for port 0 (RW) of the sky130 OpenRAM 1rw1r macros.
// Turns a valid/ready request stream into registered csb0/web0/addr0/din0,
// captures dout0 two edges after issue and returns read data in order on a
// valid/ready response stream through a credit-guarded FIFO.
// Ports:
//   CLK, RST_N                      clock (also macro clk0), async active-low reset
//   req_valid/ready/write/addr/wdata request stream; reads wait for a FIFO credit
//   rsp_valid/ready/rdata           read response stream, program order
//   sram_csb0/web0/addr0/din0       registered macro controls
//   sram_dout0                      macro read data
// Optional: define SKY130_SRAM_CTRL_STATS_EN to add stat_reads/stat_writes/stat_stalls.
module sky130_sram_rw_port_ctrl
    import sky130_sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SKY130_SRAM_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_reads,
    output logic [STAT_W-1:0]     stat_writes,
    output logic [STAT_W-1:0]     stat_stalls
`endif
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned CRD_W = credit_width(RSP_DEPTH);

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [INFLIGHT_W-1:0]   inflight;
    logic                    credit_ok;
    logic                    accept;
    logic                    rd_accept;

    // Reads still travelling towards capture already own a FIFO slot.
    assign inflight  = INFLIGHT_W'($countones(rd_pipe));
    assign credit_ok = (CRD_W'(fifo_count) + CRD_W'(inflight)) < CRD_W'(RSP_DEPTH);
    assign req_ready = req_write || credit_ok;
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_write;

    // Macro control registers; csb0 drops to idle on reset without a clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            rd_pipe    <= '0;
        end else begin
            sram_csb0 <= !accept;
            sram_web0 <= accept ? !req_write : 1'b1;
            if (accept) begin
                sram_addr0 <= req_addr;
                sram_din0  <= req_wdata;
            end
            rd_pipe <= {rd_pipe[READ_LATENCY-2:0], rd_accept};
        end
    end

    // The last pipeline stage marks the only edge where dout0 is valid.
    sky130_sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (rd_pipe[READ_LATENCY-1]),
        .push_data (sram_dout0),
        .pop       (rsp_ready),
        .pop_data  (rsp_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;

`ifdef SKY130_SRAM_CTRL_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (rd_accept && (stat_reads != '1)) begin
                stat_reads <= stat_reads + STAT_W'(1);
            end
            if (accept && req_write && (stat_writes != '1)) begin
                stat_writes <= stat_writes + STAT_W'(1);
            end
            if (req_valid && !req_ready && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sky130_sram_rw_port_ctrl.sv
// Self-checking bench for sky130_sram_rw_port_ctrl with a behavioural macro model
// and a read-data scoreboard. Inputs change #1 after posedge; outputs are sampled
// on the negedge.
module tb_sky130_sram_rw_port_ctrl;
    import sky130_sram_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       sram_csb0, sram_web0;
    logic [3:0] sram_addr0;
    logic [7:0] sram_din0;
    logic [7:0] sram_dout0;
`ifdef SKY130_SRAM_CTRL_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_stalls;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sky130_sram_rw_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RSP_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
`ifdef SKY130_SRAM_CTRL_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
        .stat_stalls(stat_stalls)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Macro model: samples controls at posedge, executes at the following negedge,
    // and corrupts dout0 shortly after the next posedge.
    logic [7:0] sram_mem [16];
    logic [7:0] ref_mem  [16];
    logic       pend_en = 1'b0;
    logic       pend_we = 1'b0;
    logic [3:0] pend_addr = '0;
    logic [7:0] pend_din  = '0;

    always @(negedge CLK) begin
        if (pend_en) begin
            if (pend_we) sram_mem[pend_addr] = pend_din;
            else         sram_dout0 = sram_mem[pend_addr];
        end
        pend_en   = !sram_csb0;
        pend_we   = !sram_web0;
        pend_addr = sram_addr0;
        pend_din  = sram_din0;
    end

    always @(posedge CLK) begin
        #1 sram_dout0 = ~sram_dout0;
    end

    // Scoreboard: expected read data pushed at acceptance, compared at delivery.
    logic [7:0] exp_q [$];

    always @(negedge CLK) begin
        if (RST_N) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 with 0x%0h, none expected", rsp_rdata);
                end else if (rsp_ready) begin
                    check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
                end else begin
                    check("rsp_hold", 32'(rsp_rdata), 32'(exp_q[0]));
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) ref_mem[req_addr] = req_wdata;
                else           exp_q.push_back(ref_mem[req_addr]);
            end
        end
    end

    task automatic drive(input logic v, input logic wr, input logic [3:0] a, input logic [7:0] d);
        req_valid = v;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Starts and ends #1 after a posedge; waits (bounded) for acceptance.
    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int waited = 0;
        drive(1'b1, wr, a, d);
        @(negedge CLK);
        while (!req_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got req_ready=0 after %0d cycles, expected 1", waited);
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge CLK); #1;
    endtask

    typedef struct {
        req_t req;
        logic exp_ready;
        logic exp_web;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int stalls;

        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = 8'(i * 29 + 7);
            ref_mem[i]  = 8'(i * 29 + 7);
        end
        sram_dout0 = '0;
        RST_N      = 1'b0;
        rsp_ready  = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'd0);

        vecs[0] = '{'{1'b1, 4'd0,  8'h00}, 1'b1, 1'b0};
        vecs[1] = '{'{1'b1, 4'd15, 8'hFF}, 1'b1, 1'b0};
        vecs[2] = '{'{1'b0, 4'd15, 8'h11}, 1'b1, 1'b1};
        vecs[3] = '{'{1'b0, 4'd0,  8'h22}, 1'b1, 1'b1};
        vecs[4] = '{'{1'b1, 4'd7,  8'h5A}, 1'b1, 1'b0};
        vecs[5] = '{'{1'b0, 4'd7,  8'h33}, 1'b1, 1'b1};
        vecs[6] = '{'{1'b0, 4'd9,  8'h44}, 1'b1, 1'b1};
        vecs[7] = '{'{1'b1, 4'd9,  8'hC3}, 1'b1, 1'b0};

        // Reset values while held in reset.
        @(negedge CLK);
        check("rst_csb",   32'(sram_csb0),  32'd1);
        check("rst_web",   32'(sram_web0),  32'd1);
        check("rst_addr",  32'(sram_addr0), 32'd0);
        check("rst_din",   32'(sram_din0),  32'd0);
        check("rst_valid", 32'(rsp_valid),  32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_csb",   32'(sram_csb0), 32'd1);
            check("idle_valid", 32'(rsp_valid), 32'd0);
        end

        // Single transactions from the vector table.
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            drive(1'b1, vecs[i].req.write, vecs[i].req.addr, vecs[i].req.wdata);
            @(negedge CLK);
            check("vec_ready", 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge CLK); #1;
            req_valid = 1'b0;
            @(negedge CLK);
            check("vec_csb",  32'(sram_csb0),  32'd0);
            check("vec_web",  32'(sram_web0),  32'(vecs[i].exp_web));
            check("vec_addr", 32'(sram_addr0), 32'(vecs[i].req.addr));
            check("vec_din",  32'(sram_din0),  32'(vecs[i].req.wdata));
            @(negedge CLK);
            check("vec_idle_csb",  32'(sram_csb0),  32'd1);
            check("vec_hold_addr", 32'(sram_addr0), 32'(vecs[i].req.addr));
        end
        wait_drain("vec_drain");

        // Write 0xA5 @3 then read @3 next cycle; data 2 cycles after read accept.
        drive(1'b1, 1'b1, 4'd3, 8'hA5);
        @(negedge CLK);
        check("raw_wr_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge CLK);
        check("raw_rd_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(negedge CLK);
        check("raw_lat0", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        check("raw_lat1", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        check("raw_lat2_valid", 32'(rsp_valid), 32'd1);
        check("raw_lat2_data",  32'(rsp_rdata), 32'hA5);
        wait_drain("raw_drain");

        // 16 back-to-back reads at full rate.
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            @(negedge CLK);
            check("b2b_ready", 32'(req_ready), 32'd1);
            @(posedge CLK); #1;
        end
        req_valid = 1'b0;
        wait_drain("b2b_drain");

        // Consumer stalled: only 4 reads fit, writes still flow.
        rsp_ready = 1'b0;
        idx = 0;
        drive(1'b1, 1'b0, 4'd8, 8'h00);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (req_ready) idx++;
            @(posedge CLK); #1;
            req_addr = 4'(8 + idx);
        end
        check("stall_accepts", 32'(idx), 32'd4);
        @(negedge CLK);
        check("stall_ready", 32'(req_ready), 32'd0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 4'd12, 8'h3C);
        @(negedge CLK);
        check("stall_write_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 4'(8 + idx), 8'h00);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            @(negedge CLK);
            if (req_ready) idx++;
            @(posedge CLK); #1;
            req_addr = 4'(8 + idx);
        end
        req_valid = 1'b0;
        check("stall_total", 32'(idx), 32'd6);
        wait_drain("stall_drain");

        // Reset between accept and capture.
        drive(1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge CLK);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("rstmid_pre_csb", 32'(sram_csb0), 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check("rstmid_csb_async", 32'(sram_csb0), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge CLK); #1;

        // Activity: 5 reads (one after 2 stall cycles), 3 writes.
        rsp_ready = 1'b0;
        idx = 0;
        stalls = 0;
        drive(1'b1, 1'b0, 4'd1, 8'h00);
        for (int c = 0; c < 20 && stalls < 2; c++) begin
            @(negedge CLK);
            if (req_ready) idx++;
            else           stalls++;
            @(posedge CLK); #1;
            req_addr = 4'(1 + idx);
        end
        req_valid = 1'b0;
        check("stats_pre_accepts", 32'(idx), 32'd4);
        rsp_ready = 1'b1;
        wait_drain("stats_drain");
        issue(1'b0, 4'd14, 8'h00);
        issue(1'b1, 4'd2,  8'h81);
        issue(1'b1, 4'd4,  8'h82);
        issue(1'b1, 4'd6,  8'h83);
        wait_drain("stats_drain2");
`ifdef SKY130_SRAM_CTRL_STATS_EN
        @(negedge CLK);
        check("stat_writes", stat_writes, 32'd3);
        check("stat_reads",  stat_reads,  32'd5);
        check("stat_stalls", stat_stalls, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
